// File: rtl/mac_seq_if.sv
// Operand/result handshake bundle for mac_seq: operand pair in, accumulator value out.
interface mac_seq_if #(
    parameter int N = 8,
    parameter int M = 8,
    parameter int G = 4
);
    localparam int ACC_W = M + N + G;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [M-1:0]     b;
    logic             sg;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] y;
    logic             busy;
    logic             ovf;

    modport master (
        output in_valid, a, b, sg, acc_clr, out_ready,
        input  in_ready, out_valid, y, busy, ovf
    );

    modport slave (
        input  in_valid, a, b, sg, acc_clr, out_ready,
        output in_ready, out_valid, y, busy, ovf
    );
endinterface

// File: rtl/mac_seq.sv
// Sequential shift-add multiply-accumulate, one multiplier bit per cycle, guarded accumulator.
// Optional MAC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// MUL   | M cycles of partial-product accumulation
// ACC   | product added into the accumulator, overflow judged
// HOLD  | result presented on y until out_ready
module mac_seq #(
    parameter int N = 8,
    parameter int M = 8,
    parameter int G = 4
) (
    input logic        clk,
    input logic        rst_n,
    mac_seq_if.slave   bus
);
    localparam int ACC_W = M + N + G;
    localparam int P_W   = M + N;
    localparam int CNT_W = $clog2(M);

    localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};

    typedef enum logic [1:0] {IDLE, MUL, ACC, HOLD} state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     a_q;
    logic [M-1:0]     b_q;
    logic             sg_q;
    logic             clr_q;
    logic [CNT_W-1:0] cnt;
    logic [P_W-1:0]   psum;
    logic [ACC_W-1:0] acc;
    logic             ovf_q;

    logic             last;
    logic [P_W-1:0]   a_ext;
    logic [P_W-1:0]   term;
    logic [P_W-1:0]   psum_nxt;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum_w;
    logic             ovf_now;
    logic [ACC_W-1:0] acc_nxt;

    assign last = (cnt == CNT_W'(M - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.in_valid)  state_nxt = MUL;
            MUL:  if (last)          state_nxt = ACC;
            ACC:                     state_nxt = HOLD;
            HOLD: if (bus.out_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // The bit M-1 term carries negative weight in two's complement, hence the subtract.
    always_comb begin
        a_ext    = sg_q ? {{M{a_q[N-1]}}, a_q} : {{M{1'b0}}, a_q};
        term     = '0;
        if (b_q[cnt]) term = a_ext << cnt;
        psum_nxt = (sg_q && last) ? (psum - term) : (psum + term);
    end

    always_comb begin
        prod_ext = sg_q ? {{G{psum[P_W-1]}}, psum} : {{G{1'b0}}, psum};
        base     = clr_q ? '0 : acc;
        sum_w    = {1'b0, base} + {1'b0, prod_ext};
        if (sg_q)
            ovf_now = (base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_w[ACC_W-1] != base[ACC_W-1]);
        else
            ovf_now = sum_w[ACC_W];
        acc_nxt  = sum_w[ACC_W-1:0];
`ifdef MAC_SATURATE_EN
        if (ovf_now) begin
            if (sg_q) acc_nxt = base[ACC_W-1] ? S_MIN : S_MAX;
            else      acc_nxt = U_MAX;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sg_q  <= 1'b0;
            clr_q <= 1'b0;
            cnt   <= '0;
            psum  <= '0;
            acc   <= '0;
            ovf_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    a_q   <= bus.a;
                    b_q   <= bus.b;
                    sg_q  <= bus.sg;
                    clr_q <= bus.acc_clr;
                    cnt   <= '0;
                    psum  <= '0;
                end
                MUL: begin
                    psum <= psum_nxt;
                    cnt  <= cnt + CNT_W'(1);
                end
                // An acc_clr operation restarts the sticky flag so it reflects only itself.
                ACC: begin
                    acc   <= acc_nxt;
                    ovf_q <= clr_q ? ovf_now : (ovf_q | ovf_now);
                end
                HOLD: ;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == HOLD);
    assign bus.busy      = (state != IDLE);
    assign bus.y         = acc;
    assign bus.ovf       = ovf_q;

`ifndef MAC_SATURATE_EN
    logic unused_sat;
    assign unused_sat = ^{S_MAX, S_MIN, U_MAX};
`endif
endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: vector table of single operations plus overflow, backpressure and reset sequences.
module tb_mac_seq;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    mac_seq_if #(.N(8), .M(8), .G(4)) bus ();

    mac_seq #(.N(8), .M(8), .G(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic        clr;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [19:0] y;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!bus.out_valid) begin
            total++;
            bad++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic do_op(input logic s, input logic c, input logic [7:0] av, input logic [7:0] bv,
                         output logic [19:0] yv, output logic ov, output int lat);
        int w;
        w = 0;
        while (!bus.in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        bus.in_valid = 1'b1;
        bus.sg       = s;
        bus.acc_clr  = c;
        bus.a        = av;
        bus.b        = bv;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(lat);
        yv = bus.y;
        ov = bus.ovf;
        @(posedge clk); #1;
    endtask

    logic [19:0] yv;
    logic        ov;
    int          lat;
    int          fired;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 8'd255, 8'd255, 20'd65025,   1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'h80,  8'h80,  20'd16384,   1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'hFF,  8'd127, 20'd16257,   1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'd3,   8'h9C,  20'd15957,   1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'd7,   8'd9,   20'd63,      1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'h80,  8'd127, 20'hFC080,   1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'd0,   8'd200, 20'hFC080,   1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'd1,   8'd1,   20'hFC081,   1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sg        = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].sg, vecs[i].clr, vecs[i].a, vecs[i].b, yv, ov, lat);
            check($sformatf("vec%0d_y", i), 32'(yv), 32'(vecs[i].y));
            check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd9);
        end

        // Unsigned overflow: 17 x 255*255
        for (int i = 0; i < 17; i++) begin
            do_op(1'b0, (i == 0), 8'd255, 8'd255, yv, ov, lat);
            if (i == 15) begin
                check("uovf_16_y", 32'(yv), 32'd1040400);
                check("uovf_16_ovf", 32'(ov), 32'd0);
            end
        end
`ifdef MAC_SATURATE_EN
        check("uovf_17_y", 32'(yv), 32'd1048575);
`else
        check("uovf_17_y", 32'(yv), 32'd56849);
`endif
        check("uovf_17_ovf", 32'(ov), 32'd1);
        do_op(1'b0, 1'b1, 8'd2, 8'd3, yv, ov, lat);
        check("uovf_clr_y", 32'(yv), 32'd6);
        check("uovf_clr_ovf", 32'(ov), 32'd0);

        // Signed positive overflow: 32 x (-128)*(-128)
        for (int i = 0; i < 32; i++) begin
            do_op(1'b1, (i == 0), 8'h80, 8'h80, yv, ov, lat);
            if (i == 30) begin
                check("sovf_31_y", 32'(yv), 32'd507904);
                check("sovf_31_ovf", 32'(ov), 32'd0);
            end
        end
`ifdef MAC_SATURATE_EN
        check("sovf_32_y", 32'(yv), 32'h7FFFF);
`else
        check("sovf_32_y", 32'(yv), 32'h80000);
`endif
        check("sovf_32_ovf", 32'(ov), 32'd1);
        do_op(1'b1, 1'b0, 8'd0, 8'd0, yv, ov, lat);
        check("sovf_sticky", 32'(ov), 32'd1);

        // Backpressure in HOLD with in_valid asserted
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.sg        = 1'b0;
        bus.acc_clr   = 1'b1;
        bus.a         = 8'd2;
        bus.b         = 8'd3;
        @(posedge clk); #1;
        bus.a       = 8'd4;
        bus.b       = 8'd5;
        bus.acc_clr = 1'b0;
        check("bp_busy", 32'(bus.busy), 32'd1);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_y_%0d", i), 32'(bus.y), 32'd6);
            check($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("bp_out_valid_%0d", i), 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_next_accept", 32'(bus.busy), 32'd1);
        wait_out(lat);
        check("bp_next_y", 32'(bus.y), 32'd26);
        check("bp_next_lat", 32'(lat), 32'd9);
        @(posedge clk); #1;

        // Reset during MUL cycle 4
        do_op(1'b0, 1'b1, 8'd20, 8'd25, yv, ov, lat);
        check("rst_pre_y", 32'(yv), 32'd500);
        bus.in_valid = 1'b1;
        bus.sg       = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.a        = 8'd10;
        bus.b        = 8'd10;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        fired = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) fired++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_out", 32'(fired), 32'd0);
        check("rst_mid_y", 32'(bus.y), 32'd0);
        check("rst_mid_ovf", 32'(bus.ovf), 32'd0);
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        do_op(1'b0, 1'b0, 8'd2, 8'd3, yv, ov, lat);
        check("rst_post_y", 32'(yv), 32'd6);
        check("rst_post_ovf", 32'(ov), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
